// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    // Controller state; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } ctrlState_t;

    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int DEF_CNT_W       = 16;

    // Wide enough for any timeout in 1..255.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of pipeline-control signals between the controller and the datapath.
// master = controller (drives enables/flush/bubble/freeze/strobe/status),
// slave  = datapath side (drives start, hazard, branch and memory status).
// Handshake: dmem_stb_o requests an access; the access completes in the
// cycle where dmem_stb_o and dmem_ack_i are both high. Without ack the
// request stays asserted and the pipeline stays frozen.
interface pipeline_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             start_i;
    logic             hazard_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             pipe_freeze_o;
    logic             dmem_stb_o;
    logic             err_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        input  start_i, hazard_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
               pipe_freeze_o, dmem_stb_o, err_o, state_o, stall_cnt_o
    );

    modport slave (
        output start_i, hazard_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
               pipe_freeze_o, dmem_stb_o, err_o, state_o, stall_cnt_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding at all-ones.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: load-use bubbles, taken-branch flushes, data-memory
// wait-state freezes with a timeout that locks into ERROR until reset.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipeline_ctrl_if.master bus
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrlState_t        state;
    logic [WAIT_W-1:0] waitCnt;

    logic dmemStb;
    logic memStall;
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExBubble;
    logic pipeFreeze;
    logic errFlag;
    logic stallInc;

    // Strobe and stall condition; an ack in the same cycle means no stall.
    always_comb begin
        dmemStb  = ((state == RUN) && bus.dmem_req_i) || (state == MEM_WAIT);
        memStall = dmemStb && !bus.dmem_ack_i;
    end

    // Pipeline control decode. Memory stall outranks hazard, which outranks
    // branch (branch operands are not valid while a load-use hazard is open).
    always_comb begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        ifIdFlush  = 1'b0;
        idExBubble = 1'b0;
        pipeFreeze = 1'b0;
        errFlag    = 1'b0;
        case (state)
            IDLE: begin
                pipeFreeze = 1'b1;
            end
            RUN, MEM_WAIT: begin
                if (memStall) begin
                    pipeFreeze = 1'b1;
                end else if (bus.hazard_i) begin
                    idExBubble = 1'b1;
                end else begin
                    pcWrite   = 1'b1;
                    ifIdWrite = 1'b1;
                    ifIdFlush = bus.branch_taken_i;
                end
            end
            ERROR: begin
                pipeFreeze = 1'b1;
                errFlag    = 1'b1;
            end
            default: begin
                pipeFreeze = 1'b1;
            end
        endcase
    end

    // State register and memory wait timer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (memStall) begin
                        state   <= MEM_WAIT;
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ack_i) begin
                        state <= RUN;
                    end else if (waitCnt == WAIT_LAST) begin
                        state <= ERROR;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every active cycle in which the PC is held counts as a stall.
    assign stallInc = ((state == RUN) || (state == MEM_WAIT)) && !pcWrite;

    sat_counter #(
        .W (CNT_W)
    ) stallCounter (
        .clk   (clk_i),
        .rstN  (rst_i),
        .inc   (stallInc),
        .count (bus.stall_cnt_o)
    );

    assign bus.pc_write_o     = pcWrite;
    assign bus.if_id_write_o  = ifIdWrite;
    assign bus.if_id_flush_o  = ifIdFlush;
    assign bus.id_ex_bubble_o = idExBubble;
    assign bus.pipe_freeze_o  = pipeFreeze;
    assign bus.dmem_stb_o     = dmemStb;
    assign bus.err_o          = errFlag;
    assign bus.state_o        = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. A second instance with a 2-bit stall
// counter shares the same inputs to exercise counter saturation.
module tb_pipeline_ctrl;

    logic clk;
    logic rst_i;
    int   errors;
    int   checks;

    pipeline_ctrl_if #(.CNT_W(16)) bus ();
    pipeline_ctrl_if #(.CNT_W(2))  bus2 ();

    // Control vector: {pc, ifid_write, flush, bubble, freeze, stb, err}
    logic [6:0] ctl;
    assign ctl = {bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o,
                  bus.id_ex_bubble_o, bus.pipe_freeze_o, bus.dmem_stb_o, bus.err_o};

    assign bus2.start_i        = bus.start_i;
    assign bus2.hazard_i       = bus.hazard_i;
    assign bus2.branch_taken_i = bus.branch_taken_i;
    assign bus2.dmem_req_i     = bus.dmem_req_i;
    assign bus2.dmem_ack_i     = bus.dmem_ack_i;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus.master)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dutSat (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus2.master)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(negedge clk);
    endtask

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    task automatic test_reset();
        rst_i = 1'b0;
        bus.start_i = 1'b1;
        bus.hazard_i = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.dmem_req_i = 1'b0;
        bus.dmem_ack_i = 1'b0;
        repeat (3) next_cycle();
        #1;
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_o); end
        checks++; if (ctl !== 7'b0000100) begin errors++; $display("FAIL reset_ctl: got %b expected 0000100", ctl); end
        checks++; if (bus.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cnt_o); end
        bus.start_i = 1'b0;
        next_cycle();
        rst_i = 1'b1;
    endtask

    task automatic test_start();
        next_cycle(); bus.start_i = 1'b1; #1;
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL start_idle_state: got %0d expected 0", bus.state_o); end
        checks++; if (ctl !== 7'b0000100) begin errors++; $display("FAIL start_idle_ctl: got %b expected 0000100", ctl); end
        next_cycle(); bus.start_i = 1'b0; #1;
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL start_run_state: got %0d expected 1", bus.state_o); end
        checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL start_run_ctl: got %b expected 1100000", ctl); end
        checks++; if (bus.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL start_stall: got %0d expected 0", bus.stall_cnt_o); end
    endtask

    task automatic test_hazard();
        next_cycle(); bus.hazard_i = 1'b1; #1;
        checks++; if (ctl !== 7'b0001000) begin errors++; $display("FAIL hazard_ctl: got %b expected 0001000", ctl); end
        next_cycle(); bus.hazard_i = 1'b0; #1;
        checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL hazard_release_ctl: got %b expected 1100000", ctl); end
        checks++; if (bus.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL hazard_stall: got %0d expected 1", bus.stall_cnt_o); end
    endtask

    task automatic test_hazard_branch();
        next_cycle(); bus.hazard_i = 1'b1; bus.branch_taken_i = 1'b1; #1;
        checks++; if (ctl !== 7'b0001000) begin errors++; $display("FAIL hzbr_priority_ctl: got %b expected 0001000", ctl); end
        next_cycle(); bus.hazard_i = 1'b0; #1;
        checks++; if (ctl !== 7'b1110000) begin errors++; $display("FAIL branch_flush_ctl: got %b expected 1110000", ctl); end
        checks++; if (bus.stall_cnt_o !== 16'd2) begin errors++; $display("FAIL hzbr_stall: got %0d expected 2", bus.stall_cnt_o); end
        checks++; if (bus2.stall_cnt_o !== sat2(2)) begin errors++; $display("FAIL hzbr_stall_sat: got %0d expected %0d", bus2.stall_cnt_o, sat2(2)); end
        next_cycle(); bus.branch_taken_i = 1'b0;
    endtask

    // Ack arrives on the 4th MEM_WAIT cycle, the last one before timeout.
    task automatic test_mem_wait();
        bus.dmem_req_i = 1'b1; bus.dmem_ack_i = 1'b0; #1;
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL mw_run_state: got %0d expected 1", bus.state_o); end
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL mw_run_ctl: got %b expected 0000110", ctl); end
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            bus.hazard_i = (k != 2);
            bus.branch_taken_i = (k != 1);
            #1;
            checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL mw_wait_state%0d: got %0d expected 2", k, bus.state_o); end
            checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL mw_wait_ctl%0d: got %b expected 0000110", k, ctl); end
            checks++; if (bus.stall_cnt_o !== 16'(2 + k)) begin errors++; $display("FAIL mw_wait_stall%0d: got %0d expected %0d", k, bus.stall_cnt_o, 2 + k); end
        end
        next_cycle(); bus.hazard_i = 1'b0; bus.branch_taken_i = 1'b0; bus.dmem_ack_i = 1'b1; #1;
        checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL mw_ack_state: got %0d expected 2", bus.state_o); end
        checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL mw_ack_ctl: got %b expected 1100010", ctl); end
        next_cycle(); bus.dmem_req_i = 1'b0; bus.dmem_ack_i = 1'b0; #1;
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL mw_back_state: got %0d expected 1", bus.state_o); end
        checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL mw_back_ctl: got %b expected 1100000", ctl); end
        checks++; if (bus.stall_cnt_o !== 16'd6) begin errors++; $display("FAIL mw_stall_total: got %0d expected 6", bus.stall_cnt_o); end
        checks++; if (bus2.stall_cnt_o !== sat2(6)) begin errors++; $display("FAIL mw_stall_sat: got %0d expected %0d", bus2.stall_cnt_o, sat2(6)); end
    endtask

    task automatic test_zero_wait();
        next_cycle(); bus.dmem_req_i = 1'b1; bus.dmem_ack_i = 1'b1; #1;
        checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL zw_ctl: got %b expected 1100010", ctl); end
        next_cycle(); bus.dmem_req_i = 1'b0; bus.dmem_ack_i = 1'b0; #1;
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL zw_state: got %0d expected 1", bus.state_o); end
        checks++; if (bus.stall_cnt_o !== 16'd6) begin errors++; $display("FAIL zw_stall: got %0d expected 6", bus.stall_cnt_o); end
    endtask

    task automatic test_timeout();
        next_cycle(); bus.dmem_req_i = 1'b1; bus.dmem_ack_i = 1'b0; #1;
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL to_run_ctl: got %b expected 0000110", ctl); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); #1;
            checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL to_wait_state%0d: got %0d expected 2", k, bus.state_o); end
            checks++; if (bus.stall_cnt_o !== 16'(6 + k)) begin errors++; $display("FAIL to_wait_stall%0d: got %0d expected %0d", k, bus.stall_cnt_o, 6 + k); end
        end
        next_cycle(); bus.start_i = 1'b1; #1;
        checks++; if (bus.state_o !== 2'd3) begin errors++; $display("FAIL to_err_state: got %0d expected 3", bus.state_o); end
        checks++; if (ctl !== 7'b0000101) begin errors++; $display("FAIL to_err_ctl: got %b expected 0000101", ctl); end
        checks++; if (bus.stall_cnt_o !== 16'd11) begin errors++; $display("FAIL to_err_stall: got %0d expected 11", bus.stall_cnt_o); end
        checks++; if (bus2.stall_cnt_o !== sat2(11)) begin errors++; $display("FAIL to_err_stall_sat: got %0d expected %0d", bus2.stall_cnt_o, sat2(11)); end
        next_cycle(); bus.start_i = 1'b0; #1;
        checks++; if (bus.state_o !== 2'd3) begin errors++; $display("FAIL to_err_sticky: got %0d expected 3", bus.state_o); end
        checks++; if (bus.stall_cnt_o !== 16'd11) begin errors++; $display("FAIL to_err_stall_hold: got %0d expected 11", bus.stall_cnt_o); end
        #2; rst_i = 1'b0; #1;
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL to_reset_state: got %0d expected 0", bus.state_o); end
        checks++; if (ctl !== 7'b0000100) begin errors++; $display("FAIL to_reset_ctl: got %b expected 0000100", ctl); end
        checks++; if (bus.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL to_reset_stall: got %0d expected 0", bus.stall_cnt_o); end
        checks++; if (bus2.stall_cnt_o !== 2'd0) begin errors++; $display("FAIL to_reset_stall_sat: got %0d expected 0", bus2.stall_cnt_o); end
        bus.dmem_req_i = 1'b0;
        next_cycle(); rst_i = 1'b1;
    endtask

    // Reset between clock edges while waiting on memory.
    task automatic test_reset_midwait();
        next_cycle(); bus.start_i = 1'b1; #1;
        next_cycle(); bus.start_i = 1'b0; bus.dmem_req_i = 1'b1; #1;
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL rmw_run_state: got %0d expected 1", bus.state_o); end
        next_cycle(); #1;
        checks++; if (bus.dmem_stb_o !== 1'b1) begin errors++; $display("FAIL rmw_stb_wait: got %b expected 1", bus.dmem_stb_o); end
        #2; rst_i = 1'b0; #1;
        checks++; if (bus.dmem_stb_o !== 1'b0) begin errors++; $display("FAIL rmw_stb_drop: got %b expected 0", bus.dmem_stb_o); end
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL rmw_state: got %0d expected 0", bus.state_o); end
        checks++; if (bus.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rmw_stall: got %0d expected 0", bus.stall_cnt_o); end
        bus.dmem_req_i = 1'b0;
        next_cycle(); rst_i = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_start();
        test_hazard();
        test_hazard_branch();
        test_mem_wait();
        test_zero_wait();
        test_timeout();
        test_reset_midwait();
        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
